// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO round-robin arbiter: FSM encodings,
// word-field positions and the one-hot helper.
package fifo_arb_pkg;

  localparam int LANES    = 4;
  localparam int DEST_MSB = 5;
  localparam int DEST_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } arb_state_t;

  // Turn a 2-bit index into a 4-bit one-hot vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible lane at or after ptr,
// wrapping 3 -> 0.
module rr_pick4
  import fifo_arb_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  logic [1:0] idx_s;

  // Scan the four lanes starting at ptr and keep the first eligible one.
  always_comb begin
    gnt       = 4'b0000;
    gnt_valid = 1'b0;
    idx_s     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr + 2'(k);
      if (!gnt_valid && eligible[idx_s]) begin
        gnt       = onehot4(idx_s);
        gnt_valid = 1'b1;
      end else begin
        gnt       = gnt;
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Moves words from four input FIFOs to four output FIFOs. Input lanes are
// served round-robin; each word goes to the output FIFO named by its top
// two bits. Traffic stops while any output FIFO raises its pause flag.
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int LANES      = 4,
  parameter int FLAG_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES-1:0]            in_empty,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic [LANES-1:0]            in_pop,
  input  logic [LANES-1:0]            out_pause,
  input  logic [LANES-1:0]            out_full,
  output logic [LANES-1:0]            out_push,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        idle,
  output logic [1:0]                  state,
  output logic                        err_drop
);

  import fifo_arb_pkg::*;

  // Mask counter wide enough to hold FLAG_LAT.
  localparam int MW = $clog2(FLAG_LAT + 1);

  arb_state_t            state_r, state_nx_s;
  logic [1:0]            rr_ptr_r;
  logic [MW-1:0]         mask_cnt_r [LANES];
  logic [LANES-1:0]      elig_s, gnt_s, pop_s;
  logic                  gnt_valid_s;
  logic [1:0]            gnt_idx_s;
  logic                  pend_vld_r;
  logic [1:0]            pend_lane_r;
  logic [DATA_WIDTH-1:0] word_s;
  logic [1:0]            dest_s;
  logic                  push_ok_s;
  logic [LANES-1:0]      out_push_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  err_drop_r, idle_r;

  rr_pick4 u_pick (
    .eligible  (elig_s),
    .ptr       (rr_ptr_r),
    .gnt       (gnt_s),
    .gnt_valid (gnt_valid_s)
  );

  // A lane is eligible when its FIFO is non-empty and its post-pop mask has expired.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < LANES; i++) begin
      elig_s[i] = !in_empty[i] && (mask_cnt_r[i] == MW'(0));
    end
  end

  // Pops only happen in ACTIVE; reset suppresses them immediately.
  always_comb begin
    if ((state_r == ST_ACTIVE) && !reset && gnt_valid_s) begin
      pop_s = gnt_s;
    end else begin
      pop_s = '0;
    end
  end

  // Encode the one-hot grant into a lane index.
  always_comb begin
    gnt_idx_s = 2'd0;
    for (int i = 0; i < LANES; i++) begin
      if (gnt_s[i]) begin
        gnt_idx_s = 2'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Select the word returned by the lane popped last cycle and decode its destination.
  always_comb begin
    case (pend_lane_r)
      2'd0:    word_s = in_data[0*DATA_WIDTH +: DATA_WIDTH];
      2'd1:    word_s = in_data[1*DATA_WIDTH +: DATA_WIDTH];
      2'd2:    word_s = in_data[2*DATA_WIDTH +: DATA_WIDTH];
      2'd3:    word_s = in_data[3*DATA_WIDTH +: DATA_WIDTH];
      default: word_s = '0;
    endcase
    dest_s    = word_s[DEST_MSB:DEST_LSB];
    push_ok_s = pend_vld_r && !out_full[dest_s];
  end

  // Next-state: pause wins, otherwise run while any lane is eligible.
  always_comb begin
    case (state_r)
      ST_IDLE, ST_ACTIVE, ST_PAUSE: begin
        if (|out_pause) begin
          state_nx_s = ST_PAUSE;
        end else if (|elig_s) begin
          state_nx_s = ST_ACTIVE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM, round-robin pointer, lane masks, two-stage word pipeline and drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= 2'd0;
      pend_vld_r  <= 1'b0;
      pend_lane_r <= 2'd0;
      out_push_r  <= '0;
      out_data_r  <= '0;
      err_drop_r  <= 1'b0;
      idle_r      <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        mask_cnt_r[i] <= MW'(0);
      end
    end else begin
      state_r <= state_nx_s;
      if (|pop_s) begin
        rr_ptr_r <= gnt_idx_s + 2'd1;
      end
      for (int i = 0; i < LANES; i++) begin
        if (pop_s[i]) begin
          mask_cnt_r[i] <= MW'(FLAG_LAT);
        end else if (mask_cnt_r[i] != MW'(0)) begin
          mask_cnt_r[i] <= mask_cnt_r[i] - MW'(1);
        end
      end
      pend_vld_r  <= |pop_s;
      pend_lane_r <= gnt_idx_s;
      out_push_r  <= push_ok_s ? onehot4(dest_s) : '0;
      if (push_ok_s) begin
        out_data_r <= word_s;
      end
      if (pend_vld_r && out_full[dest_s]) begin
        err_drop_r <= 1'b1;
      end
      idle_r <= (state_nx_s == ST_IDLE) && !(|pop_s) && !push_ok_s;
    end
  end

  assign in_pop   = pop_s;
  assign out_push = out_push_r;
  assign out_data = out_data_r;
  assign err_drop = err_drop_r;
  assign idle     = idle_r;
  assign state    = state_r;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed self-checking bench for fifo_rr_arbiter. Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_empty;
  logic [23:0] in_data;
  logic [3:0]  in_pop;
  logic [3:0]  out_pause;
  logic [3:0]  out_full;
  logic [3:0]  out_push;
  logic [5:0]  out_data;
  logic        idle;
  logic [1:0]  state;
  logic        err_drop;
  logic [5:0]  lane_data [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  assign in_data = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

  fifo_rr_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in_empty  (in_empty),
    .in_data   (in_data),
    .in_pop    (in_pop),
    .out_pause (out_pause),
    .out_full  (out_full),
    .out_push  (out_push),
    .out_data  (out_data),
    .idle      (idle),
    .state     (state),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_empty  = 4'b1111;
    out_pause = 4'b0000;
    out_full  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk_cnt++;
      if (in_pop !== 4'b0000 || idle !== 1'b1 || state !== 2'd0 || out_push !== 4'b0000)
        $display("FAIL reset_quiet c%0d: got pop=%b idle=%b state=%0d push=%b expected pop=0000 idle=1 state=0 push=0000",
                 c, in_pop, idle, state, out_push);
      else pass_cnt++;
    end
    chk_cnt++;
    if (err_drop !== 1'b0 || out_data !== 6'h00)
      $display("FAIL reset_regs: got err=%b data=%h expected err=0 data=00", err_drop, out_data);
    else pass_cnt++;
  endtask

  task automatic test_single_lane();
    do_reset();
    lane_data[2] = 6'b01_0101;
    @(negedge clk);
    in_empty = 4'b1011; #1;
    chk_cnt++;
    if (in_pop !== 4'b0000 || state !== 2'd0)
      $display("FAIL single_c0: got pop=%b state=%0d expected pop=0000 state=0", in_pop, state);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0100) $display("FAIL single_pop: got %b expected 0100", in_pop);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0000 || out_push !== 4'b0000)
      $display("FAIL single_t1: got pop=%b push=%b expected pop=0000 push=0000", in_pop, out_push);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0000 || out_push !== 4'b0010 || out_data !== 6'h15)
      $display("FAIL single_t2: got pop=%b push=%b data=%h expected pop=0000 push=0010 data=15",
               in_pop, out_push, out_data);
    else pass_cnt++;
    @(negedge clk);
    in_empty = 4'b1111; #1;
    chk_cnt++;
    if (out_push !== 4'b0000) $display("FAIL single_t3_push: got %b expected 0000", out_push);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (idle !== 1'b1 || state !== 2'd0)
      $display("FAIL single_idle: got idle=%b state=%0d expected idle=1 state=0", idle, state);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_pop  [7];
    logic [3:0] exp_push [7];
    logic [5:0] exp_data [7];
    exp_pop  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_push = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_data = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h11, 6'h22, 6'h33};
    do_reset();
    lane_data[0] = 6'h00;
    lane_data[1] = 6'h11;
    lane_data[2] = 6'h22;
    lane_data[3] = 6'h33;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      in_empty = 4'b0000; #1;
      chk_cnt++;
      if (in_pop !== exp_pop[c] || out_push !== exp_push[c] || out_data !== exp_data[c])
        $display("FAIL rr_c%0d: got pop=%b push=%b data=%h expected pop=%b push=%b data=%h",
                 c, in_pop, out_push, out_data, exp_pop[c], exp_push[c], exp_data[c]);
      else pass_cnt++;
    end
    in_empty = 4'b1111;
  endtask

  task automatic test_pause();
    logic [3:0] exp_pop  [9];
    logic [3:0] exp_push [9];
    exp_pop  = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    exp_push = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    lane_data[0] = 6'h00;
    lane_data[1] = 6'h11;
    lane_data[2] = 6'h22;
    lane_data[3] = 6'h33;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      in_empty  = 4'b0000;
      out_pause = (c >= 2 && c <= 6) ? 4'b0100 : 4'b0000;
      #1;
      chk_cnt++;
      if (in_pop !== exp_pop[c] || out_push !== exp_push[c])
        $display("FAIL pause_c%0d: got pop=%b push=%b expected pop=%b push=%b",
                 c, in_pop, out_push, exp_pop[c], exp_push[c]);
      else pass_cnt++;
      if (c == 4) begin
        chk_cnt++;
        if (state !== 2'd2) $display("FAIL pause_state: got %0d expected 2", state);
        else pass_cnt++;
      end
    end
    in_empty = 4'b1111;
  endtask

  task automatic test_full_drop();
    do_reset();
    lane_data[0] = 6'b11_0000;
    @(negedge clk);
    in_empty = 4'b1110;
    out_full = 4'b1000;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0001) $display("FAIL full_pop: got %b expected 0001", in_pop);
    else pass_cnt++;
    @(negedge clk);
    in_empty = 4'b1111; #1;
    chk_cnt++;
    if (err_drop !== 1'b0) $display("FAIL full_err_early: got %b expected 0", err_drop);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (out_push !== 4'b0000 || err_drop !== 1'b1)
      $display("FAIL full_drop: got push=%b err=%b expected push=0000 err=1", out_push, err_drop);
    else pass_cnt++;
    out_full = 4'b0000;
    for (int c = 0; c < 3; c++) @(negedge clk);
    #1;
    chk_cnt++;
    if (err_drop !== 1'b1 || out_push !== 4'b0000)
      $display("FAIL full_sticky: got err=%b push=%b expected err=1 push=0000", err_drop, out_push);
    else pass_cnt++;
    do_reset();
    #1;
    chk_cnt++;
    if (err_drop !== 1'b0) $display("FAIL full_err_clear: got %b expected 0", err_drop);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lane_data[0] = 6'h11;
    @(negedge clk);
    in_empty = 4'b1110;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0001) $display("FAIL mid_pop: got %b expected 0001", in_pop);
    else pass_cnt++;
    @(negedge clk);
    reset    = 1'b1;
    in_empty = 4'b1111; #1;
    chk_cnt++;
    if (in_pop !== 4'b0000) $display("FAIL mid_pop_in_reset: got %b expected 0000", in_pop);
    else pass_cnt++;
    @(negedge clk);
    reset    = 1'b0;
    in_empty = 4'b0000; #1;
    chk_cnt++;
    if (out_push !== 4'b0000 || state !== 2'd0 || idle !== 1'b1 || in_pop !== 4'b0000)
      $display("FAIL mid_after: got push=%b state=%0d idle=%b pop=%b expected push=0000 state=0 idle=1 pop=0000",
               out_push, state, idle, in_pop);
    else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++;
    if (in_pop !== 4'b0001 || out_push !== 4'b0000)
      $display("FAIL mid_ptr: got pop=%b push=%b expected pop=0001 push=0000", in_pop, out_push);
    else pass_cnt++;
    in_empty = 4'b1111;
  endtask

  initial begin
    reset     = 1'b1;
    in_empty  = 4'b1111;
    out_pause = 4'b0000;
    out_full  = 4'b0000;
    for (int i = 0; i < 4; i++) lane_data[i] = 6'h00;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_pause();
    test_full_drop();
    test_reset_midflight();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Moves 6-bit words from four upstream 6-bit FIFOs to four downstream 6-bit FIFOs.
- Input lanes are served round-robin.
- Each word is routed to the downstream FIFO selected by data bits [5:4].
- Sits between the input FIFO bank and the output FIFO bank.
  - Consumes their Fifo_Empty, Pausa and Fifo_Full flags.
  - Drives their pop and push strobes.
- Throttles all traffic while any downstream FIFO signals Pausa.

Parameters:
- DATA_WIDTH, 6, word width; the destination field is always the top 2 bits.
- LANES, 4, number of input FIFOs and of output FIFOs (fixed at 4 in this revision).
- FLAG_LAT, 2, cycles a lane stays masked after a pop, covering the registered empty-flag lag.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_empty  in  4  Fifo_Empty of input FIFO i.
- in_data  in  24  Fifo_Data_out of input FIFO i, packed at [6i+5:6i]; valid 1 cycle after in_pop[i].
- in_pop  out  4  one-hot pop to input FIFO i (combinational).
- out_pause  in  4  Pausa of output FIFO d.
- out_full  in  4  Fifo_Full of output FIFO d.
- out_push  out  4  one-hot push to output FIFO d (registered).
- out_data  out  6  word for out_push (registered).
- idle  out  1  high when no lane is eligible and nothing is in flight.
- state  out  2  FSM state, for debug.
- err_drop  out  1  sticky; set when a word targets an output FIFO with out_full=1.

Behaviour:
- Reset (reset=1 at a clk edge), taking effect the next cycle:
  - in_pop is forced to 0 combinationally.
  - out_push=0, out_data=0, err_drop=0, idle=1, state=IDLE.
  - rr_ptr=0, masks cleared, in-flight word discarded.
  - Reset mid-transfer loses that word; this is intended.
- Eligibility: lane i is eligible when in_empty[i]=0 and mask_cnt[i]=0.
- Pop masking: a pop of lane i loads mask_cnt[i]=FLAG_LAT, which then decrements each cycle to 0.
- Grant:
  - When state=ACTIVE, pop the first eligible lane at or after rr_ptr (wrapping 3->0).
  - On a grant to lane g, rr_ptr <= (g+1) mod 4.
  - At most one in_pop bit is set per cycle.
- Pipeline (pop at cycle t):
  - t+1: the arbiter captures in_data[g] into a holding register with a valid bit.
  - t+2: out_push[d]=1 for one cycle and out_data=word, where d=word[5:4].
  - Sustained throughput is 1 word/cycle when 3 or more lanes are eligible.
- FSM, next state evaluated every cycle:
  - IDLE: no pops. Go to PAUSE if |out_pause; else to ACTIVE if any lane eligible.
  - ACTIVE: pops allowed. Go to PAUSE if |out_pause; else to IDLE if no lane eligible.
  - PAUSE: no new pops. Leave only when out_pause==0, to ACTIVE if any lane eligible, else to IDLE.
  - State is registered; out_pause asserted at cycle t blocks pops from cycle t+1.
  - Up to 2 words already in flight still complete; the Pausa threshold (3 of 4) absorbs them.
- State encoding (shared package): IDLE=0, ACTIVE=1, PAUSE=2.
- Full protection: if out_full[d]=1 at push time, out_push stays 0, the word is dropped, and err_drop<=1 until reset.
- idle = (state==IDLE) && no in-flight word.
- Simultaneous pop of an input and push to an output in the same cycle is normal and permitted.

Decomposition:
- Package fifo_arb_pkg holds:
  - state encodings.
  - DEST_MSB=5, DEST_LSB=4.
  - LANES=4.
  - the one-hot helper function.
- One sub-module, rr_pick4: a combinational round-robin picker.
  - Inputs: eligible[3:0], ptr[1:0].
  - Outputs: gnt[3:0] one-hot, gnt_valid.
  - The top level holds the FSM, masks, pipeline and error logic.

Test Plan:
- Reset then all in_empty=1111 -> in_pop=0000 throughout, idle=1, state=IDLE, out_push=0000.
- Lane 2 only, holding word 6'b01_0101 -> in_pop=0100 at t; out_push=0010 and out_data=6'h15 at t+2; lane 2 not popped at t+1 or t+2.
- All four lanes non-empty, rr_ptr=0 -> pops 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- out_pause=0100 asserted mid-stream -> no pop from the following cycle; exactly the in-flight words are pushed; traffic resumes 1 cycle after out_pause=0000.
- Word 6'b11_0000 with out_full=1000 -> out_push stays 0000, err_drop=1 and stays set until reset.
- reset=1 for one cycle between a pop and its push -> no out_push; state=IDLE, rr_ptr=0, masks cleared.
